// File: rtl/freq_measure_gen_if.sv
// Signal bundle between the square-wave source / result consumer and freq_measure_gen.
// The slave modport is the counter's view; the master modport is the surrounding logic's view.
interface freq_measure_gen_if #(
  parameter int CNT_W = 32
);
  logic             square;
  logic             start;
  logic             cont_mode;
  logic [CNT_W-1:0] cnt_clk;
  logic [CNT_W-1:0] cnt_squ;
  logic [CNT_W-1:0] cnt_pulse;
  logic             valid;
  logic             overflow;
  logic             timeout;
  logic             busy;

  modport master (
    output square, start, cont_mode,
    input  cnt_clk, cnt_squ, cnt_pulse, valid, overflow, timeout, busy
  );

  modport slave (
    input  square, start, cont_mode,
    output cnt_clk, cnt_squ, cnt_pulse, valid, overflow, timeout, busy
  );
endinterface

// File: rtl/freq_measure_gen.sv
// Reciprocal frequency / duty-cycle counter: windows span whole input periods, opening and
// closing on synchronised rising edges, with saturating counters, timeout and continuous mode.
module freq_measure_gen #(
  parameter int CNT_W          = 32,
  parameter int GATE_CYCLES    = 100_000_000,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 200_000_000
) (
  input  logic              clk_100M,
  input  logic              rst,
  freq_measure_gen_if.slave bus
);

  localparam int GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_OPEN, MEASURE, WAIT_CLOSE} state_t;

  // Increment with saturation; the MSB of the result flags an attempt to pass the maximum.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (!en)
      return {1'b0, v};
    if (&v)
      return {1'b1, v};
    return {1'b0, v + CNT_W'(1)};
  endfunction

  state_t              state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                s_d_q;
  logic [CNT_W-1:0]    clk_q, squ_q, pulse_q;
  logic                sat_q;
  logic [GATE_W-1:0]   gate_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [CNT_W-1:0]    res_clk_q, res_squ_q, res_pulse_q;
  logic                ovf_q, valid_q, timeout_q;

  logic                s, rise;
  logic [CNT_W-1:0]    clk_d, squ_d, pulse_d;
  logic                ovf_clk, ovf_squ, ovf_pul, sat_d;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

  // Counter values as they would stand after counting the current cycle.
  always_comb begin
    {ovf_clk, clk_d}   = sat_inc(clk_q, 1'b1);
    {ovf_squ, squ_d}   = sat_inc(squ_q, rise);
    {ovf_pul, pulse_d} = sat_inc(pulse_q, s);
    sat_d = sat_q | ovf_clk | ovf_squ | ovf_pul;
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      s_d_q       <= 1'b0;
      clk_q       <= '0;
      squ_q       <= '0;
      pulse_q     <= '0;
      sat_q       <= 1'b0;
      gate_q      <= '0;
      tmo_q       <= '0;
      res_clk_q   <= '0;
      res_squ_q   <= '0;
      res_pulse_q <= '0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.square};
      s_d_q     <= s;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= WAIT_OPEN;
            tmo_q   <= '0;
          end
        end
        WAIT_OPEN: begin
          if (rise) begin
            state_q <= MEASURE;
            clk_q   <= '0;
            squ_q   <= '0;
            pulse_q <= '0;
            sat_q   <= 1'b0;
            gate_q  <= '0;
          end else if (tmo_q == TMO_LAST) begin
            timeout_q <= 1'b1;
            tmo_q     <= '0;
            state_q   <= bus.cont_mode ? WAIT_OPEN : IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        MEASURE: begin
          clk_q   <= clk_d;
          squ_q   <= squ_d;
          pulse_q <= pulse_d;
          sat_q   <= sat_d;
          gate_q  <= gate_q + GATE_W'(1);
          if (gate_q == GATE_LAST) begin
            state_q <= WAIT_CLOSE;
            tmo_q   <= '0;
          end
        end
        WAIT_CLOSE: begin
          if (rise) begin
            // The closing edge doubles as the next opening edge in continuous mode.
            res_clk_q   <= clk_d;
            res_squ_q   <= squ_d;
            res_pulse_q <= pulse_d;
            ovf_q       <= sat_d;
            valid_q     <= 1'b1;
            clk_q       <= '0;
            squ_q       <= '0;
            pulse_q     <= '0;
            sat_q       <= 1'b0;
            gate_q      <= '0;
            state_q     <= bus.cont_mode ? MEASURE : IDLE;
          end else begin
            clk_q   <= clk_d;
            squ_q   <= squ_d;
            pulse_q <= pulse_d;
            sat_q   <= sat_d;
            if (tmo_q == TMO_LAST) begin
              timeout_q <= 1'b1;
              tmo_q     <= '0;
              state_q   <= bus.cont_mode ? WAIT_OPEN : IDLE;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cnt_clk   = res_clk_q;
  assign bus.cnt_squ   = res_squ_q;
  assign bus.cnt_pulse = res_pulse_q;
  assign bus.valid     = valid_q;
  assign bus.overflow  = ovf_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
